// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: serves loads/stores from a word array
// with a fixed latency, stalling the pipeline until the access completes.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadM,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic [31:0] readdataM,
  output logic        stallM,
  output logic        memerrM,
  output logic [1:0]  state_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Handshake: a request is presented by holding memreadM/memwriteM while the
  // pipeline is frozen by stallM; the access completes in the cycle stallM
  // first drops (DONE), and request inputs are ignored in that cycle.
  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            op_wr_q, op_wr_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q;
  logic            err_q, err_d;
  logic            commit;
  logic            stall_c;
  logic [31:0]     mem_q [DEPTH];

  logic            req_any, aligned, legal, illegal;
  logic            unused_addr;

  assign req_any     = memreadM | memwriteM;
  assign aligned     = (aluoutM[1:0] == 2'b00);
  assign legal       = (memreadM ^ memwriteM) & aligned;
  assign illegal     = (memreadM & memwriteM) | (req_any & ~aligned);
  assign unused_addr = ^aluoutM[31:AW+2];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    commit  = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (legal) begin
          stall_c = 1'b1;
          op_wr_d = memwriteM;
          idx_d   = aluoutM[AW+1:2];
          wdata_d = writedataM;
          cnt_d   = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else if (illegal) begin
          err_d = 1'b1;
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
          commit  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      if (commit && !op_wr_d) rdata_q <= mem_q[idx_d];
    end
  end

  // The array is not reset; gating on reset drops any store caught by reset.
  always_ff @(posedge clk) begin
    if (reset && commit && op_wr_d) mem_q[idx_d] <= wdata_d;
  end

  assign stallM    = reset & stall_c;
  assign readdataM = rdata_q;
  assign memerrM   = err_q;
  assign state_o   = state_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the pipeline's memory-stage interface.
- Takes the M-stage request (address, write data, read/write strobes) and serves it from an internal word array with a fixed multi-cycle latency.
- Returns read data and drives a stall to the hazard unit so the pipeline freezes until the access completes.

Parameters:
DEPTH, 256, number of 32-bit words in the array; power of two, at least 2.
LATENCY, 3, stall cycles per legal access; integer, at least 1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
memreadM  input  1  M-stage load request.
memwriteM  input  1  M-stage store request.
aluoutM  input  32  byte address of the access.
writedataM  input  32  store data.
readdataM  output  32  registered load data.
stallM  output  1  combinational stall to the hazard unit; 1 freezes F/D/E/M.
memerrM  output  1  registered one-cycle pulse flagging an illegal request.

Behaviour:
- Array index is aluoutM[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses alias modulo DEPTH*4 bytes.
- A request is legal when exactly one of memreadM/memwriteM is 1 and aluoutM[1:0]==0.
- A request is illegal when both strobes are 1 or the address is misaligned.
- FSM states: IDLE, WAIT, DONE. Reset state is IDLE.
- IDLE, legal request:
  - latch op, index and writedataM;
  - load counter with LATENCY-1;
  - go to WAIT, or straight to DONE if LATENCY==1.
- IDLE, illegal request:
  - memerrM=1 on the next cycle for exactly one cycle;
  - no array access; readdataM unchanged; stallM stays 0; stay in IDLE.
- WAIT: decrement counter each cycle; go to DONE when it reaches 0.
- Array update, on the clock edge that enters DONE:
  - a store writes the latched data into the array;
  - a load copies the array word into the readdataM register.
- DONE: stallM=0 and readdataM holds the load result. Request inputs are ignored, because the same instruction is still in M and must not re-trigger. Next state is always IDLE.
- stallM = (state==IDLE & legal request) | (state==WAIT).
  - Each legal access is stalled for exactly LATENCY cycles.
  - Completion (DONE) is the (LATENCY+1)-th cycle after the request is first presented.
- readdataM keeps the last load result until the next load completes; stores and illegal requests do not change it.
- Back-to-back accesses: the next request is sampled in the IDLE cycle after DONE. Minimum spacing is LATENCY+1 cycles.
- Reset asserted (reset==0) at any time:
  - state goes to IDLE immediately; stallM drops in the same cycle;
  - readdataM=0, memerrM=0, counter=0;
  - any pending store is discarded;
  - array contents are not reset.
- Reset release: the first request is sampled on the first rising edge with reset==1.
- Read-after-write to the same word returns the new data, because the write commits before the later read is sampled.

Test Plan:
1. Reset: drive reset=0 mid-run -> readdataM=0x00000000, stallM=0, memerrM=0 in the same cycle.
2. LATENCY=3 write, then read:
   - memwriteM=1, aluoutM=0x10, writedataM=0xDEADBEEF -> stallM=1 for 3 cycles, 0 in cycle 4;
   - then memreadM=1 at 0x10 -> 3 stall cycles, readdataM=0xDEADBEEF in the DONE cycle.
3. Aliasing, DEPTH=256: write 0xCAFEF00D to 0x410, then read 0x10 -> readdataM=0xCAFEF00D.
4. Illegal requests:
   - memreadM=1 at 0x13 -> memerrM=1 for one cycle, stallM=0, readdataM unchanged;
   - memreadM=memwriteM=1 at 0x20 -> same response.
5. Reset during a store:
   - memwriteM=1 at 0x20 with 0x12345678 (old word 0x0000AAAA);
   - assert reset in WAIT -> stallM=0 at once;
   - after release, read 0x20 -> 0x0000AAAA.
6. Strobes held and back-to-back:
   - hold memreadM=1 at 0x10 through DONE -> no second access; stallM=0 in DONE, 1 again the following IDLE cycle only if the request is still presented;
   - LATENCY=1 read -> 1 stall cycle, data valid next cycle.
